// File: rtl/regfile_pkg.sv
// Shared constants for the scoreboarded register file: default geometry and
// the clear-sequencer state encoding.
package regfile_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;
  localparam int NRD_DEF    = 2;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_CLEAR = 1'b1;

endpackage

// File: rtl/regfile_sb_if.sv
// Bus bundle for regfile_sb: read ports, two write ports, claim port and
// the clear/ready handshake. The master drives requests, the slave answers.
interface regfile_sb_if
  import regfile_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int NRD    = NRD_DEF
) ();

  logic [NRD*ADDR_W-1:0] rd_addr;
  logic [NRD*DATA_W-1:0] rd_data;
  logic [NRD-1:0]        rd_busy;

  logic                  wa_en;
  logic [ADDR_W-1:0]     wa_addr;
  logic [DATA_W-1:0]     wa_data;

  logic                  wb_en;
  logic [ADDR_W-1:0]     wb_addr;
  logic [DATA_W-1:0]     wb_data;

  logic                  claim_en;
  logic [ADDR_W-1:0]     claim_addr;

  logic                  clr_start;
  logic                  ready;

  modport master (
    output rd_addr, wa_en, wa_addr, wa_data, wb_en, wb_addr, wb_data,
           claim_en, claim_addr, clr_start,
    input  rd_data, rd_busy, ready
  );

  modport slave (
    input  rd_addr, wa_en, wa_addr, wa_data, wb_en, wb_addr, wb_data,
           claim_en, claim_addr, clr_start,
    output rd_data, rd_busy, ready
  );

endinterface

// File: rtl/regfile_scoreboard.sv
// Busy-bit tracker: a claim marks a register as awaiting a producer, a write
// on either port releases it. A claim in the same cycle as a write wins.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   clear,
  input  logic                   claim_en,
  input  logic [ADDR_W-1:0]      claim_addr,
  input  logic                   wa_en,
  input  logic [ADDR_W-1:0]      wa_addr,
  input  logic                   wb_en,
  input  logic [ADDR_W-1:0]      wb_addr,
  output logic [(1<<ADDR_W)-1:0] busy
);

  // Claim is applied last so it overrides a release of the same register.
  always_ff @(posedge clk) begin
    if (!reset || clear) begin
      busy <= '0;
    end else begin
      if (wa_en)    busy[wa_addr]    <= 1'b0;
      if (wb_en)    busy[wb_addr]    <= 1'b0;
      if (claim_en) busy[claim_addr] <= 1'b1;
    end
  end

endmodule

// File: rtl/regfile_sb.sv
// Multi-read, dual-write register file with per-register busy bits, write
// bypass and a sequential clear engine that zeroes one entry per cycle.
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int NRD      = NRD_DEF,
  parameter int ZERO_REG = 1
) (
  input  logic         clk,
  input  logic         reset,
  regfile_sb_if.slave  bus
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  logic [0:0]        state;
  logic [ADDR_W-1:0] cnt;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DEPTH-1:0]  busy;

  logic idle;
  logic wa_do;
  logic wb_do;
  logic claim_do;
  logic sb_clear;

  function automatic logic is_zero_reg(input logic [ADDR_W-1:0] a);
    return (ZERO_REG != 0) && (a == '0);
  endfunction

  assign idle     = (state == ST_IDLE);
  assign wa_do    = idle && bus.wa_en    && !is_zero_reg(bus.wa_addr);
  assign wb_do    = idle && bus.wb_en    && !is_zero_reg(bus.wb_addr);
  assign claim_do = idle && bus.claim_en && !is_zero_reg(bus.claim_addr);
  // Busy bits drop on the edge that starts a clear so CLEAR never sees one set.
  assign sb_clear = !idle || bus.clr_start;
  assign bus.ready = idle;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= ST_CLEAR;
      cnt   <= '0;
    end else if (idle) begin
      if (bus.clr_start) begin
        state <= ST_CLEAR;
        cnt   <= '0;
      end
    end else begin
      cnt <= cnt + ADDR_W'(1);
      if (cnt == LAST) state <= ST_IDLE;
    end
  end

  // Storage has no reset; the clear engine zeroes it. Port B writes last.
  always_ff @(posedge clk) begin
    if (!idle) begin
      if (reset) mem[cnt] <= '0;
    end else begin
      if (wa_do) mem[bus.wa_addr] <= bus.wa_data;
      if (wb_do) mem[bus.wb_addr] <= bus.wb_data;
    end
  end

  regfile_scoreboard #(
    .ADDR_W (ADDR_W)
  ) u_scoreboard (
    .clk        (clk),
    .reset      (reset),
    .clear      (sb_clear),
    .claim_en   (claim_do),
    .claim_addr (bus.claim_addr),
    .wa_en      (wa_do),
    .wa_addr    (bus.wa_addr),
    .wb_en      (wb_do),
    .wb_addr    (bus.wb_addr),
    .busy       (busy)
  );

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [ADDR_W-1:0] addr;
    logic              hit_a;
    logic              hit_b;
    logic              hit_c;
    logic [DATA_W-1:0] data;
    logic              busy_o;

    assign addr  = bus.rd_addr[k*ADDR_W +: ADDR_W];
    assign hit_a = wa_do    && (bus.wa_addr    == addr);
    assign hit_b = wb_do    && (bus.wb_addr    == addr);
    assign hit_c = claim_do && (bus.claim_addr == addr);

    // A same-cycle write releases the register unless a new claim lands on it.
    always_comb begin
      data   = mem[addr];
      busy_o = busy[addr];
      if (!idle || is_zero_reg(addr)) begin
        data   = '0;
        busy_o = 1'b0;
      end else begin
        if (hit_b)      data = bus.wb_data;
        else if (hit_a) data = bus.wa_data;
        if ((hit_a || hit_b) && !hit_c) busy_o = 1'b0;
      end
    end

    assign bus.rd_data[k*DATA_W +: DATA_W] = data;
    assign bus.rd_busy[k]                  = busy_o;
  end

endmodule

// File: tb/tb_regfile_sb.sv
// Randomised and directed bench for regfile_sb; a queue of expected outputs
// is filled by the driver and drained by an independent negedge monitor.
module tb_regfile_sb;
  import regfile_pkg::*;

  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int NR    = 2;
  localparam int DEPTH = 1 << AW;

  typedef struct {
    bit            rst_n;
    bit            wa_en;
    logic [AW-1:0] wa_addr;
    logic [DW-1:0] wa_data;
    bit            wb_en;
    logic [AW-1:0] wb_addr;
    logic [DW-1:0] wb_data;
    bit            claim_en;
    logic [AW-1:0] claim_addr;
    bit            clr;
    logic [AW-1:0] ra [NR];
  } stim_t;

  typedef struct {
    bit            ready;
    logic [DW-1:0] data [NR];
    bit            busy [NR];
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  regfile_sb_if #(.DATA_W(DW), .ADDR_W(AW), .NRD(NR)) bus ();

  regfile_sb #(
    .DATA_W   (DW),
    .ADDR_W   (AW),
    .NRD      (NR),
    .ZERO_REG (1)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic [DW-1:0] m_mem [DEPTH];
  bit            m_busy [DEPTH];
  int            m_clear_left;
  exp_t          exp_q [$];
  int            n_checks = 0;
  int            n_pass   = 0;

  // Reference: a register array plus a countdown of clear cycles remaining.
  function automatic exp_t model_expect(input stim_t s);
    exp_t e;
    e.ready = (m_clear_left == 0);
    for (int p = 0; p < NR; p++) begin
      int  a;
      bit  wa_hit, wb_hit, cl_hit;
      a = int'(s.ra[p]);
      e.data[p] = '0;
      e.busy[p] = 1'b0;
      if (m_clear_left == 0 && a != 0) begin
        wa_hit = s.wa_en    && int'(s.wa_addr)    == a;
        wb_hit = s.wb_en    && int'(s.wb_addr)    == a;
        cl_hit = s.claim_en && int'(s.claim_addr) == a;
        e.data[p] = wb_hit ? s.wb_data : (wa_hit ? s.wa_data : m_mem[a]);
        e.busy[p] = m_busy[a] && !((wa_hit || wb_hit) && !cl_hit);
      end
    end
    return e;
  endfunction

  task automatic model_step(input stim_t s);
    if (!s.rst_n) begin
      m_clear_left = DEPTH;
      for (int i = 0; i < DEPTH; i++) m_busy[i] = 1'b0;
    end else if (m_clear_left > 0) begin
      m_mem[DEPTH - m_clear_left] = '0;
      m_clear_left--;
    end else begin
      if (s.wa_en && s.wa_addr != 0) m_mem[s.wa_addr] = s.wa_data;
      if (s.wb_en && s.wb_addr != 0) m_mem[s.wb_addr] = s.wb_data;
      if (s.clr) begin
        m_clear_left = DEPTH;
        for (int i = 0; i < DEPTH; i++) m_busy[i] = 1'b0;
      end else begin
        if (s.wa_en) m_busy[s.wa_addr] = 1'b0;
        if (s.wb_en) m_busy[s.wb_addr] = 1'b0;
        if (s.claim_en && s.claim_addr != 0) m_busy[s.claim_addr] = 1'b1;
      end
    end
  endtask

  function automatic stim_t nop(input int ra0, input int ra1);
    stim_t s;
    s = '{rst_n: 1'b1, wa_en: 1'b0, wa_addr: '0, wa_data: '0, wb_en: 1'b0,
          wb_addr: '0, wb_data: '0, claim_en: 1'b0, claim_addr: '0, clr: 1'b0,
          ra: '{default: '0}};
    s.ra[0] = AW'(ra0);
    s.ra[1] = AW'(ra1);
    return s;
  endfunction

  // Drives one cycle; the reset cycle itself has no defined output to check.
  task automatic applyStimulus(input stim_t s);
    reset          = s.rst_n;
    bus.wa_en      = s.wa_en;
    bus.wa_addr    = s.wa_addr;
    bus.wa_data    = s.wa_data;
    bus.wb_en      = s.wb_en;
    bus.wb_addr    = s.wb_addr;
    bus.wb_data    = s.wb_data;
    bus.claim_en   = s.claim_en;
    bus.claim_addr = s.claim_addr;
    bus.clr_start  = s.clr;
    bus.rd_addr    = {s.ra[1], s.ra[0]};
    if (s.rst_n) exp_q.push_back(model_expect(s));
    @(posedge clk);
    model_step(s);
    #1;
  endtask

  task automatic cmp(input string name, input logic [DW-1:0] got, input logic [DW-1:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", name, got, want, $time);
  endtask

  task automatic checkOutput(input exp_t e);
    cmp("ready", DW'(bus.ready), DW'(e.ready));
    for (int p = 0; p < NR; p++) begin
      cmp($sformatf("rd_data%0d", p), bus.rd_data[p*DW +: DW], e.data[p]);
      cmp($sformatf("rd_busy%0d", p), DW'(bus.rd_busy[p]), DW'(e.busy[p]));
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) checkOutput(exp_q.pop_front());
  end

  stim_t s;

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      m_mem[i]  = '0;
      m_busy[i] = 1'b0;
    end
    m_clear_left = 0;
    reset = 1'b1;
    bus.wa_en = 1'b0; bus.wb_en = 1'b0; bus.claim_en = 1'b0; bus.clr_start = 1'b0;
    bus.wa_addr = '0; bus.wb_addr = '0; bus.claim_addr = '0;
    bus.wa_data = '0; bus.wb_data = '0; bus.rd_addr = '0;
    @(posedge clk);
    #1;

    // Reset, then the power-on clear, then read back every register.
    s = nop(0, 0); s.rst_n = 1'b0; applyStimulus(s);
    for (int i = 0; i < DEPTH; i++) applyStimulus(nop(i, DEPTH - 1 - i));
    for (int i = 0; i < DEPTH; i++) applyStimulus(nop(i, (i + 3) % DEPTH));

    // Bypass and storage of a single write.
    s = nop(5, 0); s.wa_en = 1; s.wa_addr = 5; s.wa_data = 32'h1234; applyStimulus(s);
    applyStimulus(nop(5, 5));

    // Port B wins a same-address collision.
    s = nop(7, 7); s.wa_en = 1; s.wa_addr = 7; s.wa_data = 32'hAAAA;
    s.wb_en = 1; s.wb_addr = 7; s.wb_data = 32'hBBBB; applyStimulus(s);
    applyStimulus(nop(7, 5));

    // Claim, wait, release; then claim and write together.
    s = nop(9, 0); s.claim_en = 1; s.claim_addr = 9; applyStimulus(s);
    repeat (3) applyStimulus(nop(9, 9));
    s = nop(9, 9); s.wb_en = 1; s.wb_addr = 9; s.wb_data = 32'h55; applyStimulus(s);
    repeat (2) applyStimulus(nop(9, 0));
    s = nop(9, 9); s.claim_en = 1; s.claim_addr = 9;
    s.wa_en = 1; s.wa_addr = 9; s.wa_data = 32'h66; applyStimulus(s);
    repeat (2) applyStimulus(nop(9, 9));

    // Register zero ignores writes and claims.
    s = nop(0, 0); s.wa_en = 1; s.wa_addr = 0; s.wa_data = 32'hFFFF;
    s.claim_en = 1; s.claim_addr = 0; applyStimulus(s);
    applyStimulus(nop(0, 9));

    // Clear, reset ten cycles in, writes during the clear are dropped.
    s = nop(5, 7); s.clr = 1; applyStimulus(s);
    for (int i = 1; i < 10; i++) begin
      s = nop(5, 7); s.wa_en = 1; s.wa_addr = AW'(i + 10); s.wa_data = 32'hDEAD0000 + i;
      s.claim_en = 1; s.claim_addr = AW'(i + 10); applyStimulus(s);
    end
    s = nop(5, 7); s.rst_n = 1'b0; applyStimulus(s);
    for (int i = 0; i < DEPTH + 2; i++) applyStimulus(nop(5, (i % 16) + 10));
    for (int i = 10; i < 20; i++) applyStimulus(nop(i, 7));

    // Randomised traffic, addresses folded to a small range for collisions.
    for (int n = 0; n < 600; n++) begin
      s = nop($urandom_range(0, 7), $urandom_range(0, 7));
      s.wa_en      = ($urandom_range(0, 1) == 1);
      s.wa_addr    = AW'($urandom_range(0, 7));
      s.wa_data    = $urandom;
      s.wb_en      = ($urandom_range(0, 2) == 0);
      s.wb_addr    = AW'($urandom_range(0, 7));
      s.wb_data    = $urandom;
      s.claim_en   = ($urandom_range(0, 2) == 0);
      s.claim_addr = AW'($urandom_range(0, 7));
      s.clr        = ($urandom_range(0, 99) == 0);
      s.rst_n      = ($urandom_range(0, 199) != 0);
      applyStimulus(s);
    end
    repeat (3) applyStimulus(nop(1, 2));

    @(negedge clk);
    #1;
    cmp("queue_drain", DW'(exp_q.size()), '0);
    $display("[TB] %0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
